// File: rtl/cpr_oblk_packer.sv
// Repackages merged sub-data-field beats into a tagged beat stream, one trailer per o_blk.
// The trailer carries the block's first FDSSI, first SSI and its beat count.
module cpr_oblk_packer #(
  parameter int             DATA_WIDTH  = 24,
  parameter int             FDSSI_WIDTH = 12,
  parameter int             FDSTI_WIDTH = 8,
  parameter int             SSI_WIDTH   = 8,
  parameter int             CNT_WIDTH   = 12,
  parameter logic [5:0]     SID         = 6'h00,
  parameter int             OUT_WIDTH   = 8 + FDSTI_WIDTH + DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_wt,
  input  logic [FDSSI_WIDTH-1:0] in_fdssi,
  input  logic [FDSTI_WIDTH-1:0] in_fdsti,
  input  logic [SSI_WIDTH-1:0]   in_ssi,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_blk_tlast,
  input  logic                   in_frame_last,
  output logic                   in_ready,
  output logic                   m_tvalid,
  output logic [OUT_WIDTH-1:0]   m_tdata,
  output logic                   m_tlast,
  input  logic                   m_tready,
  output logic                   frame_done,
  output logic                   err_overflow
);

  localparam int TR_W = 8 + FDSSI_WIDTH + SSI_WIDTH + CNT_WIDTH;

  typedef enum logic [1:0] {IDLE, BODY, TRAILER} state_t;

  state_t                 state, state_nxt;
  logic [CNT_WIDTH-1:0]   cnt, cnt_nxt;
  logic                   truncated, truncated_nxt;
  logic                   frame_pend, frame_pend_nxt;
  logic                   frame_done_nxt;
  logic                   ovf_set;
  logic                   load_data, load_trailer, capture;
  logic                   free, accept, tr_fire;
  logic [FDSSI_WIDTH-1:0] first_fdssi;
  logic [SSI_WIDTH-1:0]   first_ssi;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [OUT_WIDTH-1:0] pack_trailer(
    input logic                   trunc,
    input logic [FDSSI_WIDTH-1:0] fs,
    input logic [SSI_WIDTH-1:0]   ss,
    input logic [CNT_WIDTH-1:0]   c
  );
    logic [OUT_WIDTH-1:0] w;
    w = '0;
    w[OUT_WIDTH-1 -: TR_W] = {1'b1, trunc, SID, fs, ss, c};
    return w;
  endfunction

  assign free     = !m_tvalid || m_tready;
  assign in_ready = free && (state != TRAILER);
  assign accept   = in_valid && in_ready;
  assign tr_fire  = m_tvalid && m_tready && m_tlast;

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    truncated_nxt  = truncated;
    frame_pend_nxt = frame_pend && !tr_fire;
    frame_done_nxt = frame_pend && tr_fire;
    ovf_set        = 1'b0;
    load_data      = 1'b0;
    load_trailer   = 1'b0;
    capture        = 1'b0;
    case (state)
      IDLE: begin
        if (accept && !in_wt) begin
          capture   = 1'b1;
          load_data = 1'b1;
          cnt_nxt   = CNT_WIDTH'(1);
          if (in_blk_tlast || in_frame_last) state_nxt = TRAILER;
          else                               state_nxt = BODY;
          if (in_frame_last) begin
            frame_pend_nxt = 1'b1;
            truncated_nxt  = !in_blk_tlast;
          end
        end else if (in_frame_last) begin
          frame_done_nxt = 1'b1;
        end
      end
      BODY: begin
        if (accept) begin
          if (!in_wt) begin
            load_data = 1'b1;
            cnt_nxt   = sat_inc(cnt);
            ovf_set   = &cnt;
          end
          if (in_blk_tlast) state_nxt = TRAILER;
        end
        // A frame end that is not also a block end cuts the block short.
        if (in_frame_last) begin
          state_nxt      = TRAILER;
          frame_pend_nxt = 1'b1;
          if (!(accept && in_blk_tlast)) truncated_nxt = 1'b1;
        end
      end
      TRAILER: begin
        if (free) begin
          load_trailer  = 1'b1;
          cnt_nxt       = '0;
          truncated_nxt = 1'b0;
          state_nxt     = IDLE;
        end
        if (in_frame_last) frame_pend_nxt = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control and output register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      truncated    <= 1'b0;
      frame_pend   <= 1'b0;
      frame_done   <= 1'b0;
      err_overflow <= 1'b0;
      m_tvalid     <= 1'b0;
      m_tdata      <= '0;
      m_tlast      <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      truncated    <= truncated_nxt;
      frame_pend   <= frame_pend_nxt;
      frame_done   <= frame_done_nxt;
      err_overflow <= err_overflow || ovf_set;
      if (load_data) begin
        m_tvalid <= 1'b1;
        m_tdata  <= {2'b01, SID, in_fdsti, in_data};
        m_tlast  <= 1'b0;
      end else if (load_trailer) begin
        m_tvalid <= 1'b1;
        m_tdata  <= pack_trailer(truncated, first_fdssi, first_ssi, cnt);
        m_tlast  <= 1'b1;
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      first_fdssi <= in_fdssi;
      first_ssi   <= in_ssi;
    end
  end

endmodule

// File: doc/cpr_oblk_packer.md
# cpr_oblk_packer

Downstream stage of the N-FIFO comparator merge block. It consumes the merged, registered sub-data-field stream (valid, wt, FDSSI, FDSTI, SSI, data, o_blk tlast, o_frame last) and repackages each output block (o_blk) as a tagged beat stream on a valid/ready master port, closed by one trailer beat. The trailer carries the block's first FDSSI, first SSI and beat count. It also generates the `ready` that back-pressures the merge stage.

## Interface
- DATA_WIDTH, 24, payload width of one merged beat
- FDSSI_WIDTH, 12, FDSSI field width
- FDSTI_WIDTH, 8, FDSTI field width (merge output zero-extended)
- SSI_WIDTH, 8, SSI field width
- CNT_WIDTH, 12, beat counter width
- SID, 6'h00, stream ID inserted into every beat
- OUT_WIDTH, 8+FDSTI_WIDTH+DATA_WIDTH, m_tdata width; 8+FDSSI_WIDTH+SSI_WIDTH+CNT_WIDTH must be ≤ OUT_WIDTH

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  merged beat valid
- in_wt  in  1  filler beat; consumed, never forwarded
- in_fdssi  in  FDSSI_WIDTH  beat FDSSI
- in_fdsti  in  FDSTI_WIDTH  beat FDSTI
- in_ssi  in  SSI_WIDTH  beat SSI
- in_data  in  DATA_WIDTH  beat payload
- in_blk_tlast  in  1  last beat of o_blk; aligned with in_valid
- in_frame_last  in  1  single-cycle merge-finished pulse; independent of in_valid
- in_ready  out  1  accept; drives the merge stage's ready
- m_tvalid  out  1  output valid
- m_tdata  out  OUT_WIDTH  output word
- m_tlast  out  1  high on trailer beats only
- m_tready  in  1  downstream accept
- frame_done  out  1  one-cycle pulse, frame fully emitted
- err_overflow  out  1  sticky; beat counter saturated

## Operation
- Input beat accepted when in_valid && in_ready. Output beat transferred when m_tvalid && m_tready.
- Output register free ⇔ !m_tvalid || m_tready.
- Data beat format: m_tdata = {2'b01, SID, in_fdsti, in_data}.
- Trailer format, MSB-aligned with zeros below: {2'b10 or 2'b11(truncated), SID, first_fdssi, first_ssi, beat_cnt}.
- FSM states are IDLE, BODY and TRAILER. Reset state is IDLE with cnt=0.
- IDLE, accepting a non-wt beat:
  - Capture first_fdssi and first_ssi; set cnt=1; load the data beat.
  - If in_blk_tlast, go to TRAILER; otherwise go to BODY.
- BODY, accepting a non-wt beat:
  - Load the data beat; cnt = cnt+1, saturating at 2^CNT_WIDTH−1.
  - Saturation sets err_overflow; it clears only on rst.
  - in_blk_tlast → TRAILER.
- wt beats are accepted and not output; cnt is unchanged.
  - wt with in_blk_tlast: cnt>0 → TRAILER; cnt=0 → stay IDLE, no trailer.
- TRAILER: in_ready=0. When the output register is free, load the trailer (tag 2'b10, or 2'b11 if truncated); cnt=0; go to IDLE.
- in_frame_last:
  - In BODY: set truncated and go to TRAILER. frame_done pulses the cycle after that trailer transfers.
  - In IDLE: frame_done pulses the next cycle.
  - In TRAILER: latch the pulse; frame_done pulses after the pending trailer transfers.
- in_ready = free && state != TRAILER.

## Timing
- Reset values: m_tvalid=0, m_tdata=0, m_tlast=0, in_ready=1 (IDLE, register empty), frame_done=0, err_overflow=0.
- Latency: a beat accepted at cycle t is on m_tdata at t+1.
- Trailer timing, with the last data beat accepted at t and m_tready=1: trailer at t+2, and in_ready=0 at t+1.
- Throughput is 1 beat/cycle inside a block, with one bubble per block.
- Stall: with m_tready=0, m_tdata/m_tvalid/m_tlast are held stable and in_ready=0 (register full).
- in_frame_last coinciding with an accepted in_blk_tlast: the trailer is non-truncated (2'b10), and frame_done pulses after that trailer transfers.
- Async rst mid-block: the partial block is discarded with no trailer; outputs return to reset values immediately.

## Test plan
- First-beat capture:
  - Stimulus: block of 3 beats, FDSSI 0x010/0x010/0x011, SSI 0x05, m_tready=1.
  - Required: 3 data beats, then trailer {2'b10, SID, 0x010, 0x05, cnt=3}, m_tlast=1 on the trailer only; in_ready low exactly one cycle.
- Back-pressure:
  - Stimulus: m_tready held 0 for 5 cycles mid-block.
  - Required: output word stable, in_ready=0, no beat lost or duplicated; count still correct.
- wt filtering:
  - Stimulus: beats wt=0,1,0 with tlast on the last beat.
  - Required: 2 data beats, trailer cnt=2. A lone wt beat with tlast → no output.
- Truncation:
  - Stimulus: 2 beats without tlast, then in_frame_last pulse.
  - Required: trailer tag 2'b11, cnt=2; frame_done pulses the cycle after the trailer transfers.
- Overflow (CNT_WIDTH=4):
  - Stimulus: 20-beat block.
  - Required: trailer cnt=15, err_overflow=1 and still set after the next block.
- Reset mid-block:
  - Stimulus: assert rst after 2 beats.
  - Required: m_tvalid=0 immediately, no trailer; a following 1-beat block yields trailer cnt=1.
